// File: rtl/cell_render_zoom_pkg.sv
// cell_render_zoom_pkg: screen geometry, RGB444 constants, cell record type and age palette helper.
package cell_render_zoom_pkg;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_GRID = 12'h333;
  localparam int CELL_AGE_W = 2;
  typedef struct packed {
    logic alive;
    logic [CELL_AGE_W-1:0] age;
  } cell_t;
  function automatic logic [11:0] age_colour(input int age, input int age_w);
    int step;
    logic [3:0] c;
    step = 15 / ((1 << age_w) - 1);
    c = 4'(15 - age * step);
    return {c, 4'hF, c};
  endfunction
endpackage

// File: rtl/cell_render_zoom_pipe_delay.sv
// pipe_delay: fixed-depth shift register with a configurable reset pattern.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r [DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= RST;
    end else begin
      r[0] <= d;
      for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
    end
  assign q = r[DEPTH-1];
endmodule

// File: rtl/cell_render_zoom.sv
// cell_render_zoom: raster-to-toroidal-board renderer with per-frame zoom/pan and age palette.
// Optional grid lines on dead cells at zoom >= 2 when CELL_RENDER_GRID_LINES_EN is defined.
module cell_render_zoom
  import cell_render_zoom_pkg::*;
#(
  parameter int BOARD_W_LOG2 = 6,
  parameter int BOARD_H_LOG2 = 6,
  parameter int AGE_W = 2,
  parameter int RAM_LATENCY = 2,
  parameter int ZOOM_MAX_LOG2 = 3
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [10:0]                      hcount_in,
  input  logic [9:0]                       vcount_in,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic                             blank_in,
  input  logic [1:0]                       zoom_in,
  input  logic [BOARD_W_LOG2-1:0]          pan_x_in,
  input  logic [BOARD_H_LOG2-1:0]          pan_y_in,
  output logic                             cell_rd_en_out,
  output logic [BOARD_H_LOG2+BOARD_W_LOG2-1:0] cell_addr_out,
  input  logic [AGE_W:0]                   cell_data_in,
  output logic [11:0]                      pix_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             blank_out
);
  localparam int L = 2 + RAM_LATENCY;
  logic vs_q;
  logic [1:0] zoom;
  logic [BOARD_W_LOG2-1:0] pan_x, cell_x;
  logic [BOARD_H_LOG2-1:0] pan_y, cell_y;
  logic grid, hs_d, vs_d, bl_d, gr_d;
  always_comb begin
    cell_x = BOARD_W_LOG2'(hcount_in >> zoom) + pan_x;
    cell_y = BOARD_H_LOG2'(vcount_in >> zoom) + pan_y;
  end
`ifdef CELL_RENDER_GRID_LINES_EN
  logic [10:0] hm;
  logic [9:0] vm;
  always_comb begin
    hm = ~(11'h7FF << zoom);
    vm = ~(10'h3FF << zoom);
    grid = (zoom >= 2'd2) && (~|(hcount_in & hm) || ~|(vcount_in & vm));
  end
`else
  assign grid = 1'b0;
`endif
  // new view parameters only take effect on the rising edge of vsync
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      vs_q <= 1'b0;
      zoom <= '0;
      pan_x <= '0;
      pan_y <= '0;
      cell_addr_out <= '0;
      cell_rd_en_out <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      if (vsync_in && !vs_q) begin
        zoom <= (32'(zoom_in) > ZOOM_MAX_LOG2) ? 2'(ZOOM_MAX_LOG2) : zoom_in;
        pan_x <= pan_x_in;
        pan_y <= pan_y_in;
      end
      cell_addr_out <= {cell_y, cell_x};
      cell_rd_en_out <= ~blank_in;
    end
  pipe_delay #(.WIDTH(4), .DEPTH(L - 1), .RST(4'b0010)) u_sync (
    .clk(clk_in),
    .rst(~rst_n_in),
    .d({hsync_in, vsync_in, blank_in, grid}),
    .q({hs_d, vs_d, bl_d, gr_d})
  );
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      pix_out <= RGB_BLACK;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      hsync_out <= hs_d;
      vsync_out <= vs_d;
      blank_out <= bl_d;
      pix_out <= bl_d ? RGB_BLACK :
                 cell_data_in[AGE_W] ? age_colour(int'(cell_data_in[AGE_W-1:0]), AGE_W) :
                 gr_d ? RGB_GRID : RGB_BLACK;
    end
endmodule

// File: tb/tb_cell_render_zoom.sv
// tb_cell_render_zoom: directed stimulus against a cycle-indexed behavioural model plus literal pins.
module tb_cell_render_zoom;
  localparam int L = 4;
  localparam int ZMAX = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic hsync = 1'b0, vsync = 1'b0, blank = 1'b1;
  logic [1:0] zoom = '0;
  logic [5:0] pan_x = '0, pan_y = '0;
  logic rd_en;
  logic [11:0] addr;
  logic [2:0] cell_data;
  logic [11:0] pix;
  logic hs_o, vs_o, bl_o;
  logic [2:0] board [0:4095];
  logic [2:0] ram_q1, ram_q2;
  int checks = 0, failures = 0;
  int n = 0, last_rst = -100;
  bit m_prev;
  int m_zoom, m_px, m_py;
  logic [11:0] e_pix [0:1023];
  logic [2:0] e_sync [0:1023];
  logic [11:0] e_addr [0:1023];
  logic e_rd [0:1023];
  logic [11:0] pal [4] = '{12'hFFF, 12'hAFA, 12'h5F5, 12'h0F0};

  cell_render_zoom #(.ZOOM_MAX_LOG2(ZMAX)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .zoom_in(zoom),
    .pan_x_in(pan_x), .pan_y_in(pan_y), .cell_rd_en_out(rd_en), .cell_addr_out(addr),
    .cell_data_in(cell_data), .pix_out(pix), .hsync_out(hs_o), .vsync_out(vs_o),
    .blank_out(bl_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_q1 <= board[addr];
    ram_q2 <= ram_q1;
  end
  assign cell_data = ram_q2;

  always @(posedge clk) begin
    int cx, cy, a;
    bit g;
    logic [2:0] c;
    n++;
    if (!rst_n) begin
      last_rst = n;
      m_prev = 1'b0;
      m_zoom = 0; m_px = 0; m_py = 0;
      e_addr[n] = '0;
      e_rd[n] = 1'b0;
    end else begin
      cx = ((int'(hcount) >> m_zoom) + m_px) % 64;
      cy = ((int'(vcount) >> m_zoom) + m_py) % 64;
      a = cy * 64 + cx;
      e_addr[n] = 12'(a);
      e_rd[n] = !blank;
      c = board[a];
`ifdef CELL_RENDER_GRID_LINES_EN
      g = (m_zoom >= 2) && ((int'(hcount) % (1 << m_zoom)) == 0 || (int'(vcount) % (1 << m_zoom)) == 0);
`else
      g = 1'b0;
`endif
      e_pix[n+L-1] = blank ? 12'h000 : c[2] ? pal[c[1:0]] : g ? 12'h333 : 12'h000;
      e_sync[n+L-1] = {hsync, vsync, blank};
      if (vsync && !m_prev) begin
        m_zoom = (int'(zoom) > ZMAX) ? ZMAX : int'(zoom);
        m_px = int'(pan_x);
        m_py = int'(pan_y);
      end
      m_prev = vsync;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  always @(negedge clk) begin
    if (n > 0 && n < 1000) begin
      if (n - last_rst < L) begin
        check("model_pix", 32'(pix), 32'h000);
        check("model_sync", 32'({hs_o, vs_o, bl_o}), 32'b001);
      end else begin
        check("model_pix", 32'(pix), 32'(e_pix[n]));
        check("model_sync", 32'({hs_o, vs_o, bl_o}), 32'(e_sync[n]));
      end
      check("model_addr", 32'(addr), 32'(e_addr[n]));
      check("model_rd_en", 32'(rd_en), 32'(e_rd[n]));
    end
  end

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit bl);
    hcount = 11'(h);
    vcount = 10'(v);
    hsync = hs;
    vsync = vs;
    blank = bl;
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] lit [5] = '{12'hFFF, 12'hAFA, 12'h5F5, 12'h0F0, 12'h000};
    for (int i = 0; i < 4096; i++) board[i] = 3'b000;
    board[0] = 3'b100;
    board[1] = 3'b101;
    board[2] = 3'b110;
    board[3] = 3'b111;
    board[197] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      drive(k * 7, 0, 0, 0, 0);
      check("rst_pix", 32'(pix), 32'h000);
      check("rst_blank", 32'(bl_o), 32'd1);
      check("rst_rd_en", 32'(rd_en), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < L; k++) begin
      drive(4 + k, 0, 0, 0, 0);
      check("post_rst_pix", 32'(pix), 32'h000);
      if (k < L - 1) check("post_rst_blank", 32'(bl_o), 32'd1);
    end
    drive(0, 0, 0, 0, 1);
    drive(5, 3, 0, 0, 0);
    check("lat_addr", 32'(addr), 32'd197);
    check("lat_rd_en", 32'(rd_en), 32'd1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("lat_pix_early", 32'(pix), 32'h000);
    drive(0, 0, 0, 0, 1);
    check("lat_pix", 32'(pix), 32'hFFF);
    check("lat_blank", 32'(bl_o), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(k < 5 ? k : 0, 0, k == 1, k == 2, k >= 5);
      if (k >= 3) begin
        check("palette", 32'(pix), 32'(lit[k-3]));
        check("hsync_align", 32'(hs_o), 32'(k == 4));
        check("vsync_align", 32'(vs_o), 32'(k == 5));
      end
    end
    zoom = 2'd2;
    pan_x = 6'd62;
    drive(12, 0, 0, 0, 0);
    check("latch_midframe", 32'(addr), 32'd12);
    drive(0, 0, 0, 1, 0);
    drive(12, 0, 0, 1, 0);
    check("latch_zoom_pan", 32'(addr), 32'd1);
    zoom = 2'd3;
    pan_x = 6'd0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(12, 0, 0, 1, 0);
    check("zoom_clamp", 32'(addr), 32'd3);
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      drive(k, 7, 0, 0, 1);
      check("blank_rd_en", 32'(rd_en), 32'd0);
    end
    drive(8, 5, 0, 0, 0);
    drive(9, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
`ifdef CELL_RENDER_GRID_LINES_EN
    check("grid_on", 32'(pix), 32'h333);
`else
    check("grid_on", 32'(pix), 32'h000);
`endif
    drive(0, 0, 0, 0, 1);
    check("grid_off", 32'(pix), 32'h000);
    for (int k = 0; k < 6; k++) drive(k, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(6, 0, 0, 0, 0);
    check("midrst_pix", 32'(pix), 32'h000);
    check("midrst_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(k, 0, k == 2, 0, 0);
    for (int k = 0; k < L + 2; k++) drive(0, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
